// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer for the multi-cycle MIPS core: iterative multiply/divide, MTHI/MTLO
// writes, and MFHI/MFLO read gating with pipeline stall while a result is pending.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mf_req,
  input  logic             mf_sel,
  output logic             busy,
  output logic             stall,
  output logic             hi_in,
  output logic             lo_in,
  output logic             hi_out,
  output logic             lo_out,
  output logic [WIDTH-1:0] hi_data,
  output logic [WIDTH-1:0] lo_data,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, WRITE} state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opb_q;
  logic [CW-1:0]        cnt_q;
  logic                 is_div_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 hi_in_q;
  logic                 lo_in_q;
  logic                 done_q;
  logic                 dbz_q;
  logic [WIDTH-1:0]     hi_data_q;
  logic [WIDTH-1:0]     lo_data_q;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  // Operand conditioning at issue: signed ops work on magnitudes.
  logic                 is_signed;
  logic                 rs_neg;
  logic                 rt_neg;
  logic [WIDTH-1:0]     rs_abs;
  logic [WIDTH-1:0]     rt_abs;

  always_comb begin
    is_signed = ~op[0];
    rs_neg    = is_signed & rs_val[WIDTH-1];
    rt_neg    = is_signed & rt_val[WIDTH-1];
    rs_abs    = cond_neg(rs_val, rs_neg);
    rt_abs    = cond_neg(rt_val, rt_neg);
  end

  // Radix-2 step: multiply shifts right adding into the upper half,
  // divide shifts {rem,quo} left and subtracts the divisor when it fits.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, opb_q};
    div_ge   = ~div_diff[WIDTH];
    div_next = {(div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_in_q   <= 1'b0;
      lo_in_q   <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_data_q <= '0;
      lo_data_q <= '0;
    end else begin
      hi_in_q   <= 1'b0;
      lo_in_q   <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_data_q <= '0;
      lo_data_q <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1: begin
                acc_q     <= {{WIDTH{1'b0}}, rt_abs};
                opb_q     <= rs_abs;
                is_div_q  <= 1'b0;
                neg_res_q <= rs_neg ^ rt_neg;
                neg_rem_q <= 1'b0;
                cnt_q     <= CW'(WIDTH);
                state_q   <= CALC;
              end
              3'd2, 3'd3: begin
                if (rt_val == '0) begin
                  hi_data_q <= rs_val;
                  lo_data_q <= '1;
                  hi_in_q   <= 1'b1;
                  lo_in_q   <= 1'b1;
                  done_q    <= 1'b1;
                  dbz_q     <= 1'b1;
                  state_q   <= WRITE;
                end else begin
                  acc_q     <= {{WIDTH{1'b0}}, rs_abs};
                  opb_q     <= rt_abs;
                  is_div_q  <= 1'b1;
                  neg_res_q <= rs_neg ^ rt_neg;
                  neg_rem_q <= rs_neg;
                  cnt_q     <= CW'(WIDTH);
                  state_q   <= CALC;
                end
              end
              3'd4: begin
                hi_data_q <= rs_val;
                hi_in_q   <= 1'b1;
                done_q    <= 1'b1;
                state_q   <= WRITE;
              end
              3'd5: begin
                lo_data_q <= rs_val;
                lo_in_q   <= 1'b1;
                done_q    <= 1'b1;
                state_q   <= WRITE;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        // Sign correction; remainder follows the dividend (truncation toward zero).
        FIX: begin
          if (is_div_q) begin
            hi_data_q <= cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
            lo_data_q <= cond_neg(acc_q[WIDTH-1:0], neg_res_q);
          end else begin
            {hi_data_q, lo_data_q} <= cond_neg2(acc_q, neg_res_q);
          end
          hi_in_q <= 1'b1;
          lo_in_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read enables are gated by rst too, since mf_req is not ours to clear.
  assign busy        = (state_q != IDLE);
  assign stall       = busy & (start | mf_req);
  assign hi_out      = ~rst & ~busy & mf_req & mf_sel;
  assign lo_out      = ~rst & ~busy & mf_req & ~mf_sel;
  assign hi_in       = hi_in_q;
  assign lo_in       = lo_in_q;
  assign hi_data     = hi_data_q;
  assign lo_data     = lo_data_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: arithmetic results, latency, MT writes,
// read gating, stall behaviour and mid-operation reset.
module tb_hilo_muldiv_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         mf_req = 1'b0;
  logic         mf_sel = 1'b0;
  logic         busy, stall, hi_in, lo_in, hi_out, lo_out, done, div_by_zero;
  logic [W-1:0] hi_data, lo_data;
  logic         seen;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .mf_req(mf_req), .mf_sel(mf_sel), .busy(busy), .stall(stall), .hi_in(hi_in),
    .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out), .hi_data(hi_data),
    .lo_data(lo_data), .done(done), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the sampling point of cycle 1 (start accepted at posedge 0).
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_muldiv(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                            input logic [W-1:0] exp_lo);
    issue(o, a, b);
    step(32);
    chk({tag, " cyc33 done/hi_in/lo_in/busy"}, {done, hi_in, lo_in, busy}, 4'b0001);
    step(1);
    chk({tag, " cyc34 done/hi_in/lo_in/dbz"}, {done, hi_in, lo_in, div_by_zero}, 4'b1110);
    chk({tag, " hi_data"}, hi_data, exp_hi);
    chk({tag, " lo_data"}, lo_data, exp_lo);
    step(1);
    chk({tag, " after busy/done/strobes/data"}, {busy, done, hi_in, lo_in, hi_data, lo_data}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: every output low even with requests pending.
    mf_req = 1'b1;
    mf_sel = 1'b1;
    start  = 1'b1;
    op     = 3'd4;
    #2;
    chk("reset outputs", {busy, stall, hi_in, lo_in, hi_out, lo_out, done, div_by_zero, hi_data, lo_data}, '0);
    step(2);
    chk("reset held outputs", {busy, stall, hi_in, lo_in, hi_out, lo_out, done, div_by_zero}, '0);
    @(negedge clk);
    rst    = 1'b0;
    start  = 1'b0;
    mf_req = 1'b0;
    mf_sel = 1'b0;

    run_muldiv("MULTU ffffffff*2", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_muldiv("MULT -3*5",        3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_muldiv("MULT -1*-1",       3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    run_muldiv("DIV -7/2",         3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_muldiv("DIV 7/-2",         3'd2, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
    run_muldiv("DIVU 100/7",       3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_muldiv("DIV min/-1",       3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // Divide by zero bypasses the iteration.
    issue(3'd3, 32'd100, 32'd0);
    chk("DBZ cyc1 done/dbz/hi_in/lo_in", {done, div_by_zero, hi_in, lo_in}, 4'b1111);
    chk("DBZ hi_data", hi_data, 32'd100);
    chk("DBZ lo_data", lo_data, 32'hFFFF_FFFF);
    step(1);
    chk("DBZ after busy/dbz", {busy, div_by_zero}, 2'b00);

    // MTLO then read LO; read during WRITE is stalled.
    issue(3'd5, 32'h0000_1234, 32'd0);
    chk("MTLO cyc1 done/lo_in/hi_in/dbz", {done, lo_in, hi_in, div_by_zero}, 4'b1100);
    chk("MTLO lo_data", lo_data, 32'h0000_1234);
    chk("MTLO hi_data", hi_data, 32'h0);
    mf_req = 1'b1;
    mf_sel = 1'b0;
    #1;
    chk("MF in WRITE stall/lo_out", {stall, lo_out}, 2'b10);
    step(1);
    chk("MF cyc2 stall/lo_out/hi_out/busy", {stall, lo_out, hi_out, busy}, 4'b0100);
    mf_sel = 1'b1;
    #1;
    chk("MF sel HI hi_out/lo_out", {hi_out, lo_out}, 2'b10);
    mf_req = 1'b0;

    issue(3'd4, 32'hCAFE_F00D, 32'd0);
    chk("MTHI cyc1 done/hi_in/lo_in", {done, hi_in, lo_in}, 3'b110);
    chk("MTHI hi_data", hi_data, 32'hCAFE_F00D);

    issue(3'd6, 32'h5555_5555, 32'd1);
    chk("NOP op6 busy/done/strobes", {busy, done, hi_in, lo_in}, 4'b0000);

    // MULT interrupted by reset: stalls while busy, no strobe ever.
    issue(3'd0, 32'd7, 32'd9);
    seen = hi_in | lo_in | done;
    for (int i = 0; i < 9; i++) begin
      step(1);
      seen = seen | hi_in | lo_in | done;
    end
    mf_req = 1'b1;
    mf_sel = 1'b0;
    start  = 1'b1;
    op     = 3'd4;
    rs_val = 32'hAAAA_AAAA;
    #1;
    chk("MULT cyc10 stall/lo_out/hi_out", {stall, lo_out, hi_out}, 3'b100);
    step(2);
    seen = seen | hi_in | lo_in | done;
    chk("MULT cyc12 busy/stall", {busy, stall}, 2'b11);
    rst = 1'b1;
    #1;
    chk("mid-op reset busy/stall/strobes", {busy, stall, hi_in, lo_in, done, lo_out}, '0);
    start  = 1'b0;
    mf_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      seen = seen | hi_in | lo_in | done | busy;
    end
    chk("no strobe after aborted MULT", seen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
